// File: rtl/qp_ram_wr_arbiter.sv
// Write-port controller for the 64x16 quad-port RAM: round-robin arbitration of
// NREQ requesters onto port A, plus a clear sweep after reset or on request.
module qp_ram_wr_arbiter #(
  parameter int              NREQ    = 4,
  parameter int              AW      = 6,
  parameter int              DW      = 16,
  parameter logic [DW-1:0]   CLR_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_req,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic                 ram_we,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_di,
  output logic                 busy,
  output logic [2:0]           gnt_id,
  output logic [15:0]          wr_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] di;
  } wr_t;

  state_t                     state, stateNxt;
  logic [AW-1:0]              sweepCnt;
  logic [PW-1:0]              rrPtr, rrNxt;
  wr_t                        wrQ;
  logic                       sweepWr;
  logic [NREQ-1:0][AW-1:0]    addrArr;
  logic [NREQ-1:0][DW-1:0]    dataArr;
  logic [PW-1:0]              winId;
  logic [PW:0]                idx;
  logic                       anyWin, grantEn, xfer;

  assign addrArr = req_addr;
  assign dataArr = req_data;

  // Rotating search from the RR pointer; first valid requester wins.
  always_comb begin
    winId  = '0;
    anyWin = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rrPtr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!anyWin && req_valid[idx[PW-1:0]]) begin
        anyWin = 1'b1;
        winId  = idx[PW-1:0];
      end
    end
  end

  // clr_req preempts any grant in the cycle it is seen.
  assign grantEn = rst_n && (state == RUN) && !clr_req;
  assign xfer    = grantEn && anyWin;
  assign rrNxt   = (winId == PW'(NREQ-1)) ? '0 : winId + 1'b1;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[winId] = 1'b1;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      CLEAR:   if (sweepCnt == '1) stateNxt = RUN;
      RUN:     if (clr_req)        stateNxt = CLEAR;
      default:                     stateNxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      sweepCnt <= '0;
      rrPtr    <= '0;
      wrQ      <= '0;
      sweepWr  <= 1'b0;
      gnt_id   <= '0;
      wr_cnt   <= '0;
    end else begin
      state   <= stateNxt;
      sweepWr <= (state == CLEAR);
      wrQ.we  <= 1'b0;
      if (state == CLEAR) begin
        wrQ      <= '{we: 1'b1, addr: sweepCnt, di: CLR_VAL};
        sweepCnt <= sweepCnt + 1'b1;
      end else if (clr_req) begin
        sweepCnt <= '0;
      end else if (xfer) begin
        wrQ      <= '{we: 1'b1, addr: addrArr[winId], di: dataArr[winId]};
        gnt_id   <= 3'(winId);
        wr_cnt   <= wr_cnt + 16'd1;
        rrPtr    <= rrNxt;
      end
    end
  end

  assign ram_we   = wrQ.we;
  assign ram_addr = wrQ.addr;
  assign ram_di   = wrQ.di;
  // Held through the cycle the final sweep write is on the port.
  assign busy     = (state == CLEAR) || sweepWr;

endmodule

// File: tb/tb_qp_ram_wr_arbiter.sv
// Scoreboard bench for qp_ram_wr_arbiter: a transaction-level model predicts
// grants, port writes and RAM contents; monitors compare independently.
module tb_qp_ram_wr_arbiter;
  localparam int NREQ = 4, AW = 6, DW = 16, DEPTH = 64;
  localparam logic [DW-1:0] CLRV = 16'h0000;

  logic              clk = 1'b0;
  logic              rst_n, clr_req;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              ram_we, busy;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_di;
  logic [2:0]        gnt_id;
  logic [15:0]       wr_cnt;

  qp_ram_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CLR_VAL(CLRV)) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .busy(busy), .gnt_id(gnt_id), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  // The RAM being driven: port A write, read ports modelled as direct array reads.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (ram_we === 1'b1) ram[ram_addr] <= ram_di;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] di;
    logic [2:0]    gnt;
    logic [15:0]   cnt;
    logic          busy;
    bit            full;
  } exp_t;

  exp_t            expQ[$];
  logic [NREQ-1:0] rdyQ[$];
  int vectors = 0, miscompares = 0;

  // Reference model state
  bit            mClearing = 1'b1;
  int            mSweep = 0, mRr = 0, mCnt = 0, mGnt = 0;
  logic [DW-1:0] expMem [DEPTH];
  // Requester state
  bit            pV [NREQ];
  int            pA [NREQ];
  int            pD [NREQ];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, predict, then wait out the edge.
  task automatic step(input bit rst, input bit clr);
    exp_t e;
    logic [NREQ-1:0] rdy;
    int w;
    rst_n   = !rst;
    clr_req = clr;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = pV[i];
      req_addr[i*AW +: AW]  = AW'(pA[i]);
      req_data[i*DW +: DW]  = DW'(pD[i]);
    end
    rdy = '0;
    w   = -1;
    e = '{we: 1'b0, addr: '0, di: '0, gnt: 3'(mGnt), cnt: 16'(mCnt), busy: 1'b0, full: 1'b0};
    if (rst) begin
      mClearing = 1'b1; mSweep = 0; mRr = 0; mCnt = 0; mGnt = 0;
      e.gnt = '0; e.cnt = '0; e.busy = 1'b1; e.full = 1'b1;
    end else if (mClearing) begin
      e.we = 1'b1; e.addr = AW'(mSweep); e.di = CLRV; e.busy = 1'b1;
      expMem[mSweep] = CLRV;
      mSweep++;
      if (mSweep == DEPTH) mClearing = 1'b0;
    end else if (clr) begin
      mClearing = 1'b1; mSweep = 0; e.busy = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && pV[(mRr + k) % NREQ]) w = (mRr + k) % NREQ;
      if (w >= 0) begin
        rdy[w] = 1'b1;
        e.we = 1'b1; e.addr = AW'(pA[w]); e.di = DW'(pD[w]);
        expMem[pA[w]] = DW'(pD[w]);
        mGnt = w;
        mCnt = (mCnt + 1) % 65536;
        e.gnt = 3'(w); e.cnt = 16'(mCnt);
        mRr = (w + 1) % NREQ;
        pV[w] = 1'b0;
      end
    end
    rdyQ.push_back(rdy);
    expQ.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic traffic(input int n, input logic [NREQ-1:0] mask, input int pct,
                         input int clrPm, input int rstPm);
    repeat (n) begin
      for (int i = 0; i < NREQ; i++)
        if (!pV[i] && mask[i] && $urandom_range(99) < pct) begin
          pV[i] = 1'b1;
          pA[i] = $urandom_range(DEPTH-1);
          pD[i] = $urandom_range(16'hFFFF);
        end
      step(rstPm > 0 && $urandom_range(999) < rstPm, clrPm > 0 && $urandom_range(999) < clrPm);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((pV[0] | pV[1] | pV[2] | pV[3]) && guard < 200) begin
      step(1'b0, 1'b0);
      guard++;
    end
    vectors++;
    if (guard >= 200) begin
      miscompares++;
      $display("FAIL drain: requests still pending after %0d cycles, required none", guard);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic checkMem(input string n);
    for (int a = 0; a < DEPTH; a++) chk(n, 32'(ram[a]), 32'(expMem[a]));
  endtask

  // Combinational grant monitor
  initial begin
    logic [NREQ-1:0] r;
    forever begin
      wait (rdyQ.size() > 0);
      #2;
      r = rdyQ.pop_front();
      chk("req_ready", 32'(req_ready), 32'(r));
    end
  end

  // Registered port monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL expq: DUT edge with no prediction, required one at %0t", $time);
      end else begin
        e = expQ.pop_front();
        chk("ram_we", 32'(ram_we), 32'(e.we));
        if (e.we || e.full) begin
          chk("ram_addr", 32'(ram_addr), 32'(e.addr));
          chk("ram_di",   32'(ram_di),   32'(e.di));
        end
        chk("gnt_id", 32'(gnt_id), 32'(e.gnt));
        chk("wr_cnt", 32'(wr_cnt), 32'(e.cnt));
        chk("busy",   32'(busy),   32'(e.busy));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin pV[i] = 1'b0; pA[i] = 0; pD[i] = 0; end
    for (int a = 0; a < DEPTH; a++) expMem[a] = '0;
    rst_n = 1'b0; clr_req = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    traffic(70, '0, 0, 0, 0);
    checkMem("mem_after_reset_sweep");

    pV[0] = 1'b1; pA[0] = 5; pD[0] = 16'hBEEF;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("ram5_beef", 32'(ram[5]), 32'h0000BEEF);

    traffic(12, 4'hF, 100, 0, 0);
    drain();

    // Serve requester 1 alone so the pointer lands on 2, then contend 1 vs 3.
    pV[1] = 1'b1; pA[1] = 9; pD[1] = 16'h1111;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    traffic(10, 4'b1010, 100, 0, 0);
    drain();

    for (int i = 0; i < NREQ; i++) begin
      pV[i] = 1'b1; pA[i] = $urandom_range(DEPTH-1); pD[i] = $urandom_range(16'hFFFF);
    end
    step(1'b0, 1'b1);
    traffic(66, 4'hF, 100, 0, 0);
    drain();
    checkMem("mem_after_clr_sweep");

    step(1'b0, 1'b1);
    traffic(31, '0, 0, 0, 0);
    step(1'b1, 1'b0);
    traffic(70, '0, 0, 0, 0);
    checkMem("mem_after_midsweep_reset");

    repeat (3) begin
      traffic(600, 4'hF, 40, 4, 2);
      drain();
      traffic(70, '0, 0, 0, 0);
      checkMem("mem_random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
